// File: rtl/preempt_if.sv
// Preemption arbiter handshake bundle: requests and strobes in, grant out.
interface preempt_if;
  logic       tick_1hz;
  logic [3:0] req;
  logic       system_fault;
  logic       emergency_trigger;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  modport master (
    output tick_1hz, req, system_fault,
    input  emergency_trigger, grant, grant_id,
    input  busy, timeout
  );

  modport slave (
    input  tick_1hz, req, system_fault,
    output emergency_trigger, grant, grant_id,
    output busy, timeout
  );
endinterface

// File: rtl/preempt_arbiter.sv
// Emergency-vehicle preemption arbiter with debounce, hold and lockout.
// Define PREEMPT_RR_EN for round-robin candidate selection.
module preempt_arbiter #(
  parameter int N_REQ         = 4,
  parameter int DEBOUNCE_TIME = 2,
  parameter int MIN_HOLD      = 3,
  parameter int MAX_HOLD      = 12,
  parameter int LOCKOUT_TIME  = 4
) (
  input logic      clk,
  input logic      rst,
  preempt_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, QUALIFY, ACTIVE, LOCKOUT, FAULT
  } state_t;

  localparam logic [4:0] DEB_C = 5'(DEBOUNCE_TIME);
  localparam logic [3:0] MIN_C = 4'(MIN_HOLD);
  localparam logic [4:0] MAX_C = 5'(MAX_HOLD);
  localparam logic [4:0] LCK_C = 5'(LOCKOUT_TIME);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       cnt_q;
  logic [N_REQ-1:0] sync1_q, req_s_q;
  logic [1:0]       cand_q, cand_d, pick;
  logic             max_hit;
  logic [4:0]       cnt_inc;

  logic             trig_q;
  logic [N_REQ-1:0] grant_q;
  logic [1:0]       gid_q;
  logic             busy_q;
  logic             to_q;

`ifdef PREEMPT_RR_EN
  logic [1:0] ptr_q;

  // Search upward from ptr+1; smallest offset wins.
  always_comb begin
    pick = 2'd0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req_s_q[2'(ptr_q + 2'(i))])
        pick = 2'(ptr_q + 2'(i));
    end
  end
`else
  always_comb begin
    pick = 2'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_s_q[i])
        pick = 2'(i);
    end
  end
`endif

  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    max_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_s_q) begin
          state_d = QUALIFY;
          cand_d  = pick;
        end
      end
      QUALIFY: begin
        if (!req_s_q[cand_q])
          state_d = IDLE;
        else if (bus.tick_1hz && cnt_inc == DEB_C)
          state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!req_s_q[cand_q] && cnt_q >= MIN_C) begin
          state_d = LOCKOUT;
        end else if (bus.tick_1hz && cnt_inc == MAX_C) begin
          state_d = LOCKOUT;
          max_hit = 1'b1;
        end
      end
      LOCKOUT: begin
        if (bus.tick_1hz && cnt_inc == LCK_C)
          state_d = IDLE;
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (bus.system_fault) begin
      state_d = FAULT;
      max_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sync1_q <= '0;
      req_s_q <= '0;
      cand_q  <= 2'd0;
      trig_q  <= 1'b0;
      grant_q <= '0;
      gid_q   <= 2'd0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
`ifdef PREEMPT_RR_EN
      ptr_q   <= 2'd3;
`endif
    end else begin
      sync1_q <= bus.req;
      req_s_q <= sync1_q;
      state_q <= state_d;
      cand_q  <= cand_d;
      if (state_d != state_q)
        cnt_q <= 4'd0;
      else if (bus.tick_1hz && cnt_q != 4'hf)
        cnt_q <= cnt_q + 4'd1;
      trig_q  <= (state_d == ACTIVE);
      grant_q <= (state_d == ACTIVE) ? (ONE << cand_d) : '0;
      gid_q   <= (state_d == ACTIVE) ? cand_d : 2'd0;
      busy_q  <= (state_d != IDLE);
      if (state_d == FAULT)
        to_q <= 1'b0;
      else if (state_q == QUALIFY && state_d == ACTIVE)
        to_q <= 1'b0;
      else if (max_hit)
        to_q <= 1'b1;
`ifdef PREEMPT_RR_EN
      if (state_q == QUALIFY && state_d == ACTIVE)
        ptr_q <= cand_q;
`endif
    end
  end

  assign bus.emergency_trigger = trig_q;
  assign bus.grant             = grant_q;
  assign bus.grant_id          = gid_q;
  assign bus.busy              = busy_q;
  assign bus.timeout           = to_q;

endmodule

// File: tb/tb_preempt_arbiter.sv
// Directed bench for preempt_arbiter.
// Observed vector is {trigger, grant[3:0], grant_id[1:0], busy, timeout}.
module tb_preempt_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  preempt_if bus ();

  preempt_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {bus.emergency_trigger, bus.grant,
            bus.grant_id, bus.busy, bus.timeout};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.tick_1hz = 1'b1;
    cyc(1);
    bus.tick_1hz = 1'b0;
    cyc(3);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [8:0] o;
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.tick_1hz = 1'b0;
    bus.system_fault = 1'b0;
    cyc(3);
    o = obs();
    checks++;
    if (o !== 9'b0) begin
      errors++;
      $display("FAIL reset_hold got %b want %b", o, 9'b0);
    end
    rst = 1'b0;
    cyc(2);
    o = obs();
    checks++;
    if (o !== 9'b0) begin
      errors++;
      $display("FAIL reset_idle got %b want %b", o, 9'b0);
    end
  endtask

  task automatic test_long_hold();
    logic [8:0] o;
    bus.req = 4'b0001;
    cyc(4);
    tick();
    o = obs();
    checks++;
    if (o !== 9'b0_0000_00_1_0) begin
      errors++;
      $display("FAIL hold_qualify got %b want %b", o, 9'b0_0000_00_1_0);
    end
    tick();
    o = obs();
    checks++;
    if (o !== 9'b1_0001_00_1_0) begin
      errors++;
      $display("FAIL hold_grant got %b want %b", o, 9'b1_0001_00_1_0);
    end
    ticks(8);
    o = obs();
    checks++;
    if (o !== 9'b1_0001_00_1_0) begin
      errors++;
      $display("FAIL hold_tick10 got %b want %b", o, 9'b1_0001_00_1_0);
    end
    bus.req = 4'b0000;
    cyc(4);
    o = obs();
    checks++;
    if (o !== 9'b0_0000_00_1_0) begin
      errors++;
      $display("FAIL hold_release got %b want %b", o, 9'b0_0000_00_1_0);
    end
    ticks(3);
    o = obs();
    checks++;
    if (o !== 9'b0_0000_00_1_0) begin
      errors++;
      $display("FAIL hold_lock3 got %b want %b", o, 9'b0_0000_00_1_0);
    end
    tick();
    o = obs();
    checks++;
    if (o !== 9'b0) begin
      errors++;
      $display("FAIL hold_idle got %b want %b", o, 9'b0);
    end
  endtask

  task automatic test_glitch();
    logic [8:0] o;
    bus.req = 4'b0100;
    cyc(4);
    tick();
    bus.req = 4'b0000;
    cyc(4);
    o = obs();
    checks++;
    if (o !== 9'b0) begin
      errors++;
      $display("FAIL glitch_idle got %b want %b", o, 9'b0);
    end
    tick();
    o = obs();
    checks++;
    if (o !== 9'b0) begin
      errors++;
      $display("FAIL glitch_nogrant got %b want %b", o, 9'b0);
    end
  endtask

  task automatic test_min_hold();
    logic [8:0] o;
    bus.req = 4'b0010;
    cyc(4);
    ticks(2);
    o = obs();
    checks++;
    if (o !== 9'b1_0010_01_1_0) begin
      errors++;
      $display("FAIL min_grant got %b want %b", o, 9'b1_0010_01_1_0);
    end
    tick();
    bus.req = 4'b0000;
    cyc(4);
    o = obs();
    checks++;
    if (o !== 9'b1_0010_01_1_0) begin
      errors++;
      $display("FAIL min_cnt1 got %b want %b", o, 9'b1_0010_01_1_0);
    end
    tick();
    o = obs();
    checks++;
    if (o !== 9'b1_0010_01_1_0) begin
      errors++;
      $display("FAIL min_cnt2 got %b want %b", o, 9'b1_0010_01_1_0);
    end
    tick();
    o = obs();
    checks++;
    if (o !== 9'b0_0000_00_1_0) begin
      errors++;
      $display("FAIL min_lockout got %b want %b", o, 9'b0_0000_00_1_0);
    end
    ticks(4);
  endtask

  task automatic test_timeout_rotation();
    logic [8:0] o;
    logic [8:0] e;
    logic [1:0] id;
    bus.req = 4'b1111;
    cyc(4);
    for (int k = 0; k < 5; k++) begin
`ifdef PREEMPT_RR_EN
      id = 2'(k);
`else
      id = 2'd0;
`endif
      ticks(2);
      e = {1'b1, 4'b0001 << id, id, 1'b1, 1'b0};
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rot%0d_grant got %b want %b", k, o, e);
      end
      ticks(11);
      o = obs();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rot%0d_tick11 got %b want %b", k, o, e);
      end
      tick();
      o = obs();
      checks++;
      if (o !== 9'b0_0000_00_1_1) begin
        errors++;
        $display("FAIL rot%0d_timeout got %b want %b", k, o,
                 9'b0_0000_00_1_1);
      end
      ticks(4);
    end
    bus.req = 4'b0000;
    cyc(4);
    o = obs();
    checks++;
    if (o !== 9'b0_0000_00_0_1) begin
      errors++;
      $display("FAIL rot_idle got %b want %b", o, 9'b0_0000_00_0_1);
    end
  endtask

  task automatic test_fault();
    logic [8:0] o;
    bus.req = 4'b0001;
    cyc(4);
    ticks(2);
    o = obs();
    checks++;
    if (o !== 9'b1_0001_00_1_0) begin
      errors++;
      $display("FAIL fault_pre got %b want %b", o, 9'b1_0001_00_1_0);
    end
    bus.system_fault = 1'b1;
    cyc(1);
    bus.system_fault = 1'b0;
    o = obs();
    checks++;
    if (o !== 9'b0_0000_00_1_0) begin
      errors++;
      $display("FAIL fault_enter got %b want %b", o, 9'b0_0000_00_1_0);
    end
    bus.req = 4'b1111;
    ticks(6);
    o = obs();
    checks++;
    if (o !== 9'b0_0000_00_1_0) begin
      errors++;
      $display("FAIL fault_stay got %b want %b", o, 9'b0_0000_00_1_0);
    end
    bus.req = 4'b0000;
    #2 rst = 1'b1;
    #1;
    o = obs();
    checks++;
    if (o !== 9'b0) begin
      errors++;
      $display("FAIL fault_rst got %b want %b", o, 9'b0);
    end
    cyc(2);
    rst = 1'b0;
    cyc(4);
    o = obs();
    checks++;
    if (o !== 9'b0) begin
      errors++;
      $display("FAIL fault_idle got %b want %b", o, 9'b0);
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] o;
    bus.req = 4'b0001;
    cyc(4);
    ticks(2);
    o = obs();
    checks++;
    if (o !== 9'b1_0001_00_1_0) begin
      errors++;
      $display("FAIL arst_pre got %b want %b", o, 9'b1_0001_00_1_0);
    end
    #2 rst = 1'b1;
    #1;
    o = obs();
    checks++;
    if (o !== 9'b0) begin
      errors++;
      $display("FAIL arst_drop got %b want %b", o, 9'b0);
    end
    bus.req = 4'b1000;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    tick();
    o = obs();
    checks++;
    if (o !== 9'b0_0000_00_1_0) begin
      errors++;
      $display("FAIL arst_qual got %b want %b", o, 9'b0_0000_00_1_0);
    end
    tick();
    o = obs();
    checks++;
    if (o !== 9'b1_1000_11_1_0) begin
      errors++;
      $display("FAIL arst_grant got %b want %b", o, 9'b1_1000_11_1_0);
    end
    bus.req = 4'b0000;
    cyc(4);
    ticks(4);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_long_hold();
    test_glitch();
    test_min_hold();
    test_timeout_rotation();
    test_fault();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
